eth_test_frame_gen: RTL and testbench



---
 rtl/eth_test_frame_gen.sv | 213 +++++++++++++++++++++
 tb/tb_eth_test_frame_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_test_frame_gen.sv
// eth_test_frame_gen: synthetic Ethernet frame source for the 10G MAC AXI-Stream TX port.
// Emits fixed-header frames with a 32-bit sequence number and a byte-index payload.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   start, stop         run control pulses (start honoured only when idle)
//   frame_len           frame length in bytes without FCS, clamped to [60, 9600]
//   ifg_cycles          idle cycles between frames
//   burst_count         frames per run, 0 = continuous
//   busy, frames_sent   run status
//   m_axis_*            64-bit AXI-Stream master towards the MAC
//   err_inject          only with TEST_GEN_ERR_INJECT_EN: arm one FCS error (tuser on tlast)
module eth_test_frame_gen #(
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h000A_3500_0001,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [13:0]          frame_len,
    input  logic [7:0]           ifg_cycles,
    input  logic [CNT_WIDTH-1:0] burst_count,
`ifdef TEST_GEN_ERR_INJECT_EN
    input  logic                 err_inject,
`endif
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frames_sent,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [63:0]          m_axis_tdata,
    output logic [7:0]           m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser
);

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP} state_t;

    state_t               state, state_d;
    logic [10:0]          beat, nbeats;
    logic [7:0]           keep_last;
    logic [31:0]          seq, seq_d;
    logic                 stop_pend;
    logic [7:0]           gap_cnt;

    logic                 accept, last_acc, stop_any, run_done;
    logic [CNT_WIDTH-1:0] fs_inc;
    logic                 load, adv;
    logic [13:0]          len_c, len_p7;
    logic [10:0]          nb_c, nb_sel, beat_nx;
    logic [7:0]           keep_c, keep_sel;
    logic                 tlast_nx, tvalid_d, tlast_d;
    logic [63:0]          data_nx;

    // Header is bytes 0..17, payload byte n carries n[7:0].
    function automatic logic [63:0] beat_data(input logic [10:0] k,
                                              input logic [31:0] sq);
        logic [143:0] hdr;
        logic [13:0]  n;
        logic [63:0]  d;
        int           idx;
        hdr = {DST_MAC, SRC_MAC, ETHERTYPE, sq};
        d   = '0;
        for (int i = 0; i < 8; i++) begin
            n = {k, i[2:0]};
            if (n < 14'd18) begin
                idx = 17 - int'(n);
                d[8*i +: 8] = hdr[8*idx +: 8];
            end else begin
                d[8*i +: 8] = n[7:0];
            end
        end
        return d;
    endfunction

    assign accept   = m_axis_tvalid & m_axis_tready;
    assign last_acc = accept & m_axis_tlast;
    assign stop_any = stop_pend | stop;
    assign fs_inc   = frames_sent + 1'b1;
    assign run_done = stop_any ||
                      (burst_count != '0 && fs_inc == burst_count);

    assign len_c  = (frame_len < 14'd60)   ? 14'd60   :
                    (frame_len > 14'd9600) ? 14'd9600 : frame_len;
    assign len_p7 = len_c + 14'd7;
    assign nb_c   = len_p7[13:3];
    // Shift by (8 - L%8) mod 8: a full last beat needs no shift.
    assign keep_c = 8'hFF >> (3'd0 - len_c[2:0]);

    always_comb begin
        state_d = state;
        load    = 1'b0;
        adv     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FRAME;
                    load    = 1'b1;
                end
            end
            S_FRAME: begin
                if (last_acc) begin
                    if (run_done)
                        state_d = S_IDLE;
                    else if (ifg_cycles == 8'd0)
                        load = 1'b1;
                    else
                        state_d = S_GAP;
                end else if (accept) begin
                    adv = 1'b1;
                end
            end
            S_GAP: begin
                if (stop_any) begin
                    state_d = S_IDLE;
                end else if (gap_cnt == 8'd1) begin
                    state_d = S_FRAME;
                    load    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if (state == S_IDLE)
            seq_d = start ? 32'd0 : seq;
        else
            seq_d = last_acc ? seq + 32'd1 : seq;
        nb_sel   = load ? nb_c : nbeats;
        keep_sel = load ? keep_c : keep_last;
        beat_nx  = load ? 11'd0 : beat + 11'd1;
        tlast_nx = (beat_nx == nb_sel - 11'd1);
        data_nx  = beat_data(beat_nx, seq_d);
        tvalid_d = m_axis_tvalid;
        tlast_d  = m_axis_tlast;
        if (load | adv) begin
            tvalid_d = 1'b1;
            tlast_d  = tlast_nx;
        end else if (last_acc) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            frames_sent   <= '0;
            seq           <= '0;
            stop_pend     <= 1'b0;
            gap_cnt       <= '0;
            beat          <= '0;
            nbeats        <= '0;
            keep_last     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state         <= state_d;
            busy          <= (state_d != S_IDLE);
            seq           <= seq_d;
            m_axis_tvalid <= tvalid_d;
            m_axis_tlast  <= tlast_d;
            if (state == S_IDLE) begin
                stop_pend <= 1'b0;
                if (start)
                    frames_sent <= '0;
            end else begin
                stop_pend <= (state_d != S_IDLE) & stop_any;
                if (last_acc)
                    frames_sent <= fs_inc;
            end
            if (state == S_FRAME && last_acc)
                gap_cnt <= ifg_cycles;
            else if (state == S_GAP)
                gap_cnt <= gap_cnt - 8'd1;
            if (load) begin
                nbeats    <= nb_c;
                keep_last <= keep_c;
            end
            if (load | adv) begin
                beat         <= beat_nx;
                m_axis_tdata <= data_nx;
                m_axis_tkeep <= tlast_nx ? keep_sel : 8'hFF;
            end
        end
    end

`ifdef TEST_GEN_ERR_INJECT_EN
    logic err_armed, err_armed_d;

    // A pulse landing on the errored beat's acceptance arms the next frame.
    assign err_armed_d = (err_armed & ~(last_acc & m_axis_tuser)) | err_inject;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_armed    <= 1'b0;
            m_axis_tuser <= 1'b0;
        end else begin
            err_armed    <= err_armed_d;
            m_axis_tuser <= tvalid_d & tlast_d & err_armed_d;
        end
    end
`else
    assign m_axis_tuser = 1'b0;
`endif

endmodule

// File: tb/tb_eth_test_frame_gen.sv
// tb_eth_test_frame_gen: randomized self-checking bench for eth_test_frame_gen.
// A negedge monitor rebuilds frames byte by byte and compares them to a byte-level model.
module tb_eth_test_frame_gen;

    localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC = 48'h000A_3500_0001;
    localparam logic [15:0] ETY = 16'h88B5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [13:0] frame_len = '0;
    logic [7:0]  ifg_cycles = '0;
    logic [31:0] burst_count = '0;
    logic        busy;
    logic [31:0] frames_sent;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
`ifdef TEST_GEN_ERR_INJECT_EN
    logic        err_inject = 1'b0;
`endif

    eth_test_frame_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .frame_len    (frame_len),
        .ifg_cycles   (ifg_cycles),
        .burst_count  (burst_count),
`ifdef TEST_GEN_ERR_INJECT_EN
        .err_inject   (err_inject),
`endif
        .busy         (busy),
        .frames_sent  (frames_sent),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_len(input int len);
        if (len < 60)   return 60;
        if (len > 9600) return 9600;
        return len;
    endfunction

    function automatic logic [7:0] exp_byte(input int n, input int sq);
        logic [31:0] s;
        s = sq;
        if (n < 6)  return 8'(DST >> (8 * (5 - n)));
        if (n < 12) return 8'(SRC >> (8 * (11 - n)));
        if (n < 14) return 8'(ETY >> (8 * (13 - n)));
        if (n < 18) return 8'(s >> (8 * (17 - n)));
        return 8'(n);
    endfunction

    function automatic logic [7:0] exp_keep(input int len);
        if (len % 8 == 0) return 8'hFF;
        return 8'((1 << (len % 8)) - 1);
    endfunction

    // monitor state, owned by the negedge process except where the test resets it between runs
    int          exp_seq = 0;
    int          exp_len = 60;
    int          exp_gap = 0;
    int          err_seq = -1;
    int          frames_rx = 0;
    int          cur_beats = 0;
    int          idle_cnt = 0;
    int          tuser_mid = 0;
    bit          in_frame = 0;
    bit          have_prev = 0;
    bit          prev_stall = 0;
    logic [72:0] prev_beat;
    logic [63:0] b0, b1;
    logic [7:0]  lkeep;
    logic [7:0]  fbytes[$];
    int          errs;
    logic [31:0] got_seq;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame   = 0;
            have_prev  = 0;
            prev_stall = 0;
            cur_beats  = 0;
            tuser_mid  = 0;
            fbytes.delete();
        end else begin
            if (prev_stall)
                check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep,
                      m_axis_tdata}, {1'b1, prev_beat});
            if (in_frame)
                check("valid_hold", m_axis_tvalid, 1);
            if (m_axis_tvalid && !in_frame) begin
                in_frame = 1;
                if (have_prev)
                    check("gap", idle_cnt, exp_gap);
            end
            if (!m_axis_tvalid)
                idle_cnt++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                if (cur_beats == 0) b0 = m_axis_tdata;
                if (cur_beats == 1) b1 = m_axis_tdata;
                for (int i = 0; i < 8; i++)
                    if (m_axis_tkeep[i])
                        fbytes.push_back(m_axis_tdata[8*i +: 8]);
                if (m_axis_tuser && !m_axis_tlast)
                    tuser_mid++;
                cur_beats++;
                if (m_axis_tlast) begin
                    errs = 0;
                    foreach (fbytes[n])
                        if (fbytes[n] !== exp_byte(n, exp_seq))
                            errs++;
                    got_seq = '0;
                    if (fbytes.size() >= 18)
                        got_seq = {fbytes[14], fbytes[15], fbytes[16], fbytes[17]};
                    check("len", fbytes.size(), exp_len);
                    check("beats", cur_beats, (exp_len + 7) / 8);
                    check("keep_last", m_axis_tkeep, exp_keep(exp_len));
                    check("seq", got_seq, exp_seq);
                    check("bytes", errs, 0);
                    check("tuser_last", m_axis_tuser, exp_seq == err_seq);
                    check("tuser_mid", tuser_mid, 0);
                    lkeep     = m_axis_tkeep;
                    frames_rx++;
                    exp_seq++;
                    cur_beats = 0;
                    tuser_mid = 0;
                    in_frame  = 0;
                    idle_cnt  = 0;
                    have_prev = 1;
                    fbytes.delete();
                end
            end
        end
    end

    bit rand_rdy = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy)
            m_axis_tready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int len, input int ifg, input int burst, input bit rnd);
        frame_len   = 14'(len);
        ifg_cycles  = 8'(ifg);
        burst_count = burst;
        exp_len     = clamp_len(len);
        exp_gap     = ifg;
        exp_seq     = 0;
        frames_rx   = 0;
        have_prev   = 0;
        rand_rdy    = rnd;
        if (!rnd)
            m_axis_tready = 1'b1;
        check("pre_start_valid", m_axis_tvalid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_valid", m_axis_tvalid, 1);
        check("start_busy", busy, 1);
    endtask

    task automatic wait_idle(input int max);
        int c = 0;
        while (busy && c < max) begin
            tick();
            c++;
        end
        if (busy)
            check("idle_timeout", 1, 0);
        rand_rdy      = 0;
        m_axis_tready = 1'b1;
    endtask

    task automatic wait_mon(input int sq, input int bts);
        int c = 0;
        while (!(exp_seq == sq && cur_beats >= bts) && c < 20000) begin
            tick();
            c++;
        end
        if (c >= 20000)
            check("mon_timeout", 1, 0);
    endtask

    task automatic check_zero(input string tag);
        check(tag, {busy, frames_sent, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
              m_axis_tlast, m_axis_tuser}, '0);
    endtask

    initial begin
        int len, ifg, bc;
        repeat (3) tick();
        check_zero("reset_hold");
        rst_n = 1'b1;
        tick();
        check_zero("reset_state");

        // single 64-byte frame
        run(64, 0, 1, 0);
        wait_idle(200);
        check("t1_beat0", b0, 64'h0A00_FFFF_FFFF_FFFF);
        check("t1_beat1", b1, 64'h0000_B588_0100_0035);
        check("t1_keep", lkeep, 8'hFF);
        check("t1_sent", frames_sent, 1);
        check("t1_rx", frames_rx, 1);
        check("t1_busy", busy, 0);

        // odd length and clamps
        run(61, 0, 1, 0);
        wait_idle(200);
        check("t2_keep61", lkeep, 8'h1F);
        run(12, 0, 1, 0);
        wait_idle(200);
        check("t2_keep12", lkeep, 8'h0F);
        run(16000, 0, 1, 0);
        wait_idle(2000);
        check("t2_rx_big", frames_rx, 1);

        // backpressure
        run(1500, 3, 3, 1);
        wait_idle(5000);
        check("t3_sent", frames_sent, 3);
        check("t3_rx", frames_rx, 3);

        // continuous with gap, ignored start, stop mid-frame 4
        run(200, 5, 0, 0);
        wait_mon(1, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_mon(4, 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(2000);
        check("t4_sent", frames_sent, 5);
        check("t4_rx", frames_rx, 5);

        // back-to-back
        run(60, 0, 3, 0);
        wait_idle(200);
        check("t4b_sent", frames_sent, 3);

        // stop together with last-beat acceptance of frame 1
        run(60, 0, 0, 0);
        wait_mon(1, 7);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(200);
        check("t4c_sent", frames_sent, 2);
        check("t4c_rx", frames_rx, 2);

`ifdef TEST_GEN_ERR_INJECT_EN
        err_seq = 2;
        run(200, 2, 4, 0);
        wait_mon(2, 3);
        err_inject = 1'b1;
        tick();
        err_inject = 1'b0;
        tick();
        err_inject = 1'b1;
        tick();
        err_inject = 1'b0;
        wait_idle(1000);
        check("t5_sent", frames_sent, 4);
        err_seq = -1;
`endif

        // randomized runs
        for (int r = 0; r < 5; r++) begin
            len = int'($urandom_range(0, 2200));
            ifg = int'($urandom_range(0, 4));
            bc  = int'($urandom_range(1, 3));
            run(len, ifg, bc, 1);
            wait_idle(20000);
            check("rnd_sent", frames_sent, bc);
            check("rnd_rx", frames_rx, bc);
        end

        // reset mid-frame, then restart from sequence 0
        run(200, 0, 1, 0);
        wait_mon(0, 3);
        rst_n = 1'b0;
        #1;
        check_zero("t6_async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        run(64, 0, 1, 0);
        wait_idle(200);
        check("t6_rx", frames_rx, 1);
        check("t6_sent", frames_sent, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
